// File: rtl/gray_sweep_pkg.sv
// Shared types for the Gray-code hazard sweep sequencer.
package gray_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWELL  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int M_DEFAULT = 3;

endpackage

// File: rtl/gray_sweep_next.sv
// Combinational M-bit Gray successor: Gray -> binary, +1, -> Gray, wrapping naturally.
module gray_next
    import gray_sweep_pkg::*;
#(
    parameter int M = M_DEFAULT
) (
    input  logic [M-1:0] gray,
    output logic [M-1:0] succ
);

    logic [M-1:0] bin;
    logic [M-1:0] bin_inc;

    always_comb begin
        // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
        bin     = '0;
        bin_inc = '0;
        succ    = '0;
        for (int i = 0; i < M; i++) begin
            bin[i] = ^(gray >> i);
        end
        bin_inc = bin + M'(1);
        succ    = bin_inc ^ (bin_inc >> 1);
    end

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Gray-code hazard sweep sequencer: steps codes, dwells, samples hazard_in, reports results.
// Define HAZARD_STOP_EN to end the sweep at the first sampled hazard.
module gray_sweep_ctrl
    import gray_sweep_pkg::*;
#(
    parameter int M  = M_DEFAULT,
    parameter int SW = M + 1,
    parameter int DW = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] step_count,
    input  logic [DW-1:0] dwell,
    input  logic          hazard_in,
    output logic [M-1:0]  gray_code,
    output logic          gray_valid,
    output logic          busy,
    output logic          done,
    output logic          hazard_seen,
    output logic [M-1:0]  hazard_code,
    output logic [CW-1:0] hazard_cnt
);

`ifdef HAZARD_STOP_EN
    localparam bit STOP_ON_HAZARD = 1'b1;
`else
    localparam bit STOP_ON_HAZARD = 1'b0;
`endif

    state_t        state;
    logic [SW-1:0] step_q;
    logic [SW-1:0] step_cnt;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_cnt;
    logic [M-1:0]  gray_succ;
    logic [SW-1:0] step_nxt;
    logic          last_sample;

    gray_next #(.M(M)) u_next (
        .gray (gray_code),
        .succ (gray_succ)
    );

    assign step_nxt    = step_cnt + SW'(1);
    assign last_sample = (step_nxt == step_q) || (STOP_ON_HAZARD && hazard_in);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step_q      <= '0;
            step_cnt    <= '0;
            dwell_q     <= '0;
            dwell_cnt   <= '0;
            gray_code   <= '0;
            gray_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hazard_seen <= 1'b0;
            hazard_code <= '0;
            hazard_cnt  <= '0;
        end else begin
            gray_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort && step_count != '0) begin
                        state       <= DWELL;
                        busy        <= 1'b1;
                        gray_code   <= '0;
                        step_q      <= step_count;
                        step_cnt    <= '0;
                        dwell_q     <= dwell;
                        dwell_cnt   <= dwell;
                        hazard_seen <= 1'b0;
                        hazard_code <= '0;
                        hazard_cnt  <= '0;
                    end
                end
                DWELL: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dwell_cnt == '0) begin
                        state      <= SAMPLE;
                        gray_valid <= 1'b1;
                    end else begin
                        dwell_cnt <= dwell_cnt - DW'(1);
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (hazard_in) begin
                            if (hazard_cnt != '1) hazard_cnt <= hazard_cnt + CW'(1);
                            if (!hazard_seen) begin
                                hazard_seen <= 1'b1;
                                hazard_code <= gray_code;
                            end
                        end
                        step_cnt <= step_nxt;
                        if (last_sample) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= DWELL;
                            gray_code <= gray_succ;
                            dwell_cnt <= dwell_q;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed self-checking bench for gray_sweep_ctrl (M=3); honours HAZARD_STOP_EN if defined.
module tb_gray_sweep_ctrl;

    localparam int M  = 3;
    localparam int SW = 4;
    localparam int DW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] step_count = '0;
    logic [DW-1:0] dwell = '0;
    logic          hazard_in;
    logic [M-1:0]  gray_code;
    logic          gray_valid;
    logic          busy;
    logic          done;
    logic          hazard_seen;
    logic [M-1:0]  hazard_code;
    logic [CW-1:0] hazard_cnt;

    logic          haz_en = 1'b0;
    logic [7:0]    haz_mask = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    logic [M-1:0] valid_codes[$];
    int           valid_edges[$];
    int           done_edge;
    int           done_pulses;

    // Expected M=3 Gray sequence from code 0.
    logic [M-1:0] exp_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    assign hazard_in = haz_en & haz_mask[gray_code];

    always #5 clk = ~clk;

    gray_sweep_ctrl #(.M(M), .SW(SW), .DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .step_count  (step_count),
        .dwell       (dwell),
        .hazard_in   (hazard_in),
        .gray_code   (gray_code),
        .gray_valid  (gray_valid),
        .busy        (busy),
        .done        (done),
        .hazard_seen (hazard_seen),
        .hazard_code (hazard_code),
        .hazard_cnt  (hazard_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({gray_code, gray_valid, busy, done, hazard_seen, hazard_code, hazard_cnt});
    endfunction

    // Pulse start (edge 0), then record samples and done until busy drops or the budget runs out.
    task automatic run_sweep(input logic [SW-1:0] sc, input logic [DW-1:0] dw, input bit hold_start);
        valid_codes.delete();
        valid_edges.delete();
        done_edge   = -1;
        done_pulses = 0;
        step_count  = sc;
        dwell       = dw;
        start       = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        if (hold_start) step_count = 4'd8;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (gray_valid) begin
                valid_codes.push_back(gray_code);
                valid_edges.push_back(k);
            end
            if (done) begin
                done_pulses++;
                if (done_edge < 0) done_edge = k;
            end
            if (!busy) break;
        end
        start = 1'b0;
        check("sweep_ended", 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        check("reset_outputs", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", all_outs(), 32'd0);

        // Full period sweep, no dwell, no hazards.
        run_sweep(4'd8, 4'd0, 1'b0);
        check("full_n_samples", 32'(valid_codes.size()), 32'd8);
        for (int i = 0; i < 8 && i < valid_codes.size(); i++) begin
            check($sformatf("full_code%0d", i), 32'(valid_codes[i]), 32'(exp_seq[i]));
            check($sformatf("full_edge%0d", i), 32'(valid_edges[i]), 32'(2 * i + 1));
        end
        check("full_done_edge", 32'(done_edge), 32'd16);
        check("full_done_pulses", 32'(done_pulses), 32'd1);
        check("full_hazard_seen", 32'(hazard_seen), 32'd0);
        check("full_hazard_cnt", 32'(hazard_cnt), 32'd0);
        check("full_code_held", 32'(gray_code), 32'b100);

        // Dwell timing: each code occupies dwell+2 = 5 edges.
        run_sweep(4'd2, 4'd3, 1'b0);
        check("dwell_n_samples", 32'(valid_codes.size()), 32'd2);
        if (valid_codes.size() == 2) begin
            check("dwell_edge0", 32'(valid_edges[0]), 32'd4);
            check("dwell_edge1", 32'(valid_edges[1]), 32'd9);
            check("dwell_code1", 32'(valid_codes[1]), 32'b001);
        end
        check("dwell_done_edge", 32'(done_edge), 32'd10);

        // Hazard capture on codes 011 and 101.
        haz_mask = 8'b0010_1000;
        haz_en   = 1'b1;
        run_sweep(4'd8, 4'd0, 1'b0);
        haz_en = 1'b0;
        check("haz_seen", 32'(hazard_seen), 32'd1);
        check("haz_code", 32'(hazard_code), 32'b011);
`ifdef HAZARD_STOP_EN
        check("haz_cnt", 32'(hazard_cnt), 32'd1);
        check("haz_done_edge", 32'(done_edge), 32'd6);
        check("haz_n_samples", 32'(valid_codes.size()), 32'd3);
`else
        check("haz_cnt", 32'(hazard_cnt), 32'd2);
        check("haz_done_edge", 32'(done_edge), 32'd16);
        check("haz_n_samples", 32'(valid_codes.size()), 32'd8);
`endif

        // Zero-step start: nothing happens, results untouched.
        step_count = '0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("zero_done", 32'(done), 32'd0);
        check("zero_hazard_kept", 32'({hazard_seen, hazard_code}), 32'({1'b1, 3'b011}));

        // Wrap past the full period.
        run_sweep(4'd10, 4'd0, 1'b0);
        check("wrap_n_samples", 32'(valid_codes.size()), 32'd10);
        if (valid_codes.size() == 10) begin
            check("wrap_code8", 32'(valid_codes[8]), 32'b000);
            check("wrap_code9", 32'(valid_codes[9]), 32'b001);
        end
        check("wrap_done_edge", 32'(done_edge), 32'd20);
        check("wrap_code_held", 32'(gray_code), 32'b001);

        // Abort in the DWELL of the third code (dwell=2, code 2 dwells after edges 8..10).
        step_count = 4'd8;
        dwell      = 4'd2;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("abort_pre_state", 32'({busy, gray_valid, gray_code}), 32'({1'b1, 1'b0, 3'b011}));
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_code_held", 32'(gray_code), 32'b011);
        @(posedge clk); #1;
        check("abort_stays_idle", 32'({busy, done}), 32'd0);

        // abort together with start in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_idle", 32'(busy), 32'd0);

        // start held high while busy with a different step_count is ignored.
        run_sweep(4'd2, 4'd0, 1'b1);
        check("busy_start_n_samples", 32'(valid_codes.size()), 32'd2);
        check("busy_start_done_edge", 32'(done_edge), 32'd4);

        // Asynchronous reset mid-sweep.
        haz_mask = 8'h01;
        haz_en   = 1'b1;
        step_count = 4'd8;
        dwell      = 4'd0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("midrst_pre_busy", 32'({busy, hazard_seen}), 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", all_outs(), 32'd0);
        haz_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_idle", all_outs(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
